ex_branch_predictor: RTL and testbench
======================================

# ex_branch_predictor

Bimodal branch predictor that drives `pred_taken` into the EX stage and trains from EX resolution. A table of 2-bit saturating counters is read combinationally with the fetch PC and written once per resolved branch. Prediction and resolution are carried down the pipe alongside the instruction. The block also keeps branch and misprediction statistics for the performance counters.

## Interface
Parameters:
- `IDX_W`, 6: table index width; the table has 2^IDX_W entries.
- `STAT_W`, 16: width of each statistics counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_pc`  in  32  word address of the instruction being fetched.
- `pred_en`  in  1  1: dynamic prediction; 0: static not-taken.
- `pred_taken`  out  1  prediction for `if_pc`; travels with the instruction to EX.
- `ex_valid`  in  1  EX holds a valid, unflushed, unstalled instruction.
- `ex_is_branch`  in  1  EX instruction is a conditional branch.
- `ex_pc`  in  32  word address of the EX instruction (EX `pc_1` − 1).
- `ex_taken`  in  1  resolved branch outcome from EX.
- `ex_pred_taken`  in  1  prediction that was issued with the EX instruction.
- `tbl_clr`  in  1  synchronous clear of the whole table.
- `stat_clr`  in  1  synchronous clear of both statistics counters.
- `branch_cnt`  out  STAT_W  resolved branches since reset or clear.
- `mispred_cnt`  out  STAT_W  mispredicted branches since reset or clear.

## Operation
- Counter encoding: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11. The prediction is counter bit 1.
- Lookup index = `if_pc[IDX_W-1:0]`. Update index = `ex_pc[IDX_W-1:0]`. No tags; aliasing is accepted.
- `upd = ex_valid & ex_is_branch`.
- On `upd`, the counter at the update index trains on `ex_taken`:
  - taken: increment, saturating at ST.
  - not taken: decrement, saturating at SNT.
- `pred_taken = pred_en & cnt_next[1]`, where `cnt_next` selects between two values:
  - the post-update value, when `upd` is high and the lookup index equals the update index (write-first bypass);
  - otherwise the stored counter.
- `tbl_clr`: every entry becomes WNT at the next edge. It has priority over a same-cycle update, which is dropped. While `tbl_clr` is high, the bypass is disabled and `pred_taken = 0`.
- Statistics on `upd`:
  - `branch_cnt` increments.
  - `mispred_cnt` increments when `ex_taken != ex_pred_taken`.
  - Both saturate at all-ones and do not wrap.
- `stat_clr` zeroes both statistics counters and has priority over a same-cycle increment.
- The table trains regardless of `pred_en`.
- `ex_is_branch` with `ex_valid` low: no table or statistics change.

## Timing
- Reset (`rst_n` low, asynchronous): all entries become WNT and both statistics counters become 0.
  - With the table at WNT, `pred_taken` is 0 during and after reset.
  - `branch_cnt` and `mispred_cnt` are 0 during and after reset.
- A reset asserted mid-update discards that update.
- Lookup is zero-latency combinational from `if_pc`, `pred_en`, table state and the bypass inputs.
- A table write commits at the edge where `upd` is high. It is visible in the same cycle through the bypass and in later cycles through stored state.
- Statistics outputs are registered and reflect an update one cycle after the `upd` cycle.
- One update per cycle; EX resolves at most one branch per cycle.
- No handshake. Stall and flush qualification belong to the caller and are folded into `ex_valid`.

## Structure
- Shared package `bp_pkg` holds:
  - counter encodings `BP_SNT`, `BP_WNT`, `BP_WT`, `BP_ST` and the reset value `BP_INIT = BP_WNT`;
  - default `IDX_W` and `STAT_W`.
- One sub-module, `bp_sat_ctr`: combinational 2-bit saturating next-state function (`cnt_in`, `taken` → `cnt_out`).
  - Instantiated once, for the update path.
  - Its output feeds both the table write and the bypass mux.
- Table storage is a flop array with async reset, not inferred RAM, because it requires a reset image and a single-cycle clear.

## Test plan
- Reset, then `if_pc=0x10` with `pred_en=1` → `pred_taken=0`, `branch_cnt=0`, `mispred_cnt=0`.
- Two taken updates at `ex_pc=0x05` (`ex_pred_taken=0`), then lookup `if_pc=0x45` (aliases index 5 with `IDX_W=6`) → `pred_taken=1`, `branch_cnt=2`, `mispred_cnt=2`.
- Four taken then one not-taken update at index 3 → counter sequence WT, ST, ST, ST, WT; prediction remains 1.
- Same-cycle update (`upd=1`, `ex_taken=1`, index 9 currently WNT) with `if_pc` index 9 → `pred_taken=1` in that cycle; with `pred_en=0` in that cycle → 0.
- `tbl_clr` together with a taken update at index 2 (currently ST) → index 2 reads WNT the next cycle; `branch_cnt` still increments.
- Preload `branch_cnt` near all-ones via 0xFFFF+2 updates → holds at 0xFFFF; `stat_clr` with a concurrent `upd` → both counters read 0.

Source files
------------

// File: rtl/ex_branch_predictor_pkg.sv
// Shared types and defaults for the bimodal branch predictor.
package bp_pkg;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_cnt_e;

  localparam bp_cnt_e BP_INIT   = BP_WNT;
  localparam int      BP_IDX_W  = 6;
  localparam int      BP_STAT_W = 16;

endpackage

// File: rtl/ex_branch_predictor_if.sv
// Fetch lookup, EX resolution and statistics bundle between pipeline and predictor.
interface ex_branch_predictor_if #(
  parameter int STAT_W = bp_pkg::BP_STAT_W
);
  logic [31:0]       if_pc;
  logic              pred_en;
  logic              pred_taken;
  logic              ex_valid;
  logic              ex_is_branch;
  logic [31:0]       ex_pc;
  logic              ex_taken;
  logic              ex_pred_taken;
  logic              tbl_clr;
  logic              stat_clr;
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] mispred_cnt;

  modport master (
    output if_pc, pred_en, ex_valid, ex_is_branch, ex_pc, ex_taken,
           ex_pred_taken, tbl_clr, stat_clr,
    input  pred_taken, branch_cnt, mispred_cnt
  );

  modport slave (
    input  if_pc, pred_en, ex_valid, ex_is_branch, ex_pc, ex_taken,
           ex_pred_taken, tbl_clr, stat_clr,
    output pred_taken, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/ex_branch_predictor_sat_ctr.sv
// 2-bit saturating counter next-state function.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  bp_cnt_e cnt_in,
  input  logic    taken,
  output bp_cnt_e cnt_out
);

  always_comb begin
    cnt_out = cnt_in;
    if (taken) begin
      if (cnt_in != BP_ST) cnt_out = bp_cnt_e'(cnt_in + 2'd1);
    end else begin
      if (cnt_in != BP_SNT) cnt_out = bp_cnt_e'(cnt_in - 2'd1);
    end
  end

endmodule

// File: rtl/ex_branch_predictor.sv
// Bimodal predictor: flop table of 2-bit counters, write-first bypass, branch statistics.
module ex_branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W  = BP_IDX_W,
  parameter int STAT_W = BP_STAT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ex_branch_predictor_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  bp_cnt_e           tbl [DEPTH];
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              upd;
  bp_cnt_e           cnt_upd;
  bp_cnt_e           cnt_next;
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] mispred_cnt;
  logic              unused_pc_hi;

  assign rd_idx       = bus.if_pc[IDX_W-1:0];
  assign wr_idx       = bus.ex_pc[IDX_W-1:0];
  assign upd          = bus.ex_valid & bus.ex_is_branch;
  assign unused_pc_hi = ^{bus.if_pc[31:IDX_W], bus.ex_pc[31:IDX_W]};

  bp_sat_ctr u_sat_ctr (
    .cnt_in  (tbl[wr_idx]),
    .taken   (bus.ex_taken),
    .cnt_out (cnt_upd)
  );

  // Bypass shows the counter value this edge will commit; a clear drops the update.
  always_comb begin
    cnt_next = tbl[rd_idx];
    if (upd && !bus.tbl_clr && (rd_idx == wr_idx)) cnt_next = cnt_upd;
  end

  assign bus.pred_taken = bus.pred_en & ~bus.tbl_clr & cnt_next[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl[i[IDX_W-1:0]] <= BP_INIT;
    end else if (bus.tbl_clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl[i[IDX_W-1:0]] <= BP_INIT;
    end else if (upd) begin
      tbl[wr_idx] <= cnt_upd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (bus.stat_clr) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (upd) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
      if ((bus.ex_taken != bus.ex_pred_taken) && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

  assign bus.branch_cnt  = branch_cnt;
  assign bus.mispred_cnt = mispred_cnt;

endmodule

// File: tb/tb_ex_branch_predictor.sv
// Directed vector table, saturation/reset sequences and randomized model check for ex_branch_predictor.
module tb_ex_branch_predictor;

  localparam int IDX_W  = 6;
  localparam int STAT_W = 16;
  localparam int NENT   = 1 << IDX_W;
  localparam int SMAX   = (1 << STAT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_branch_predictor_if #(.STAT_W(STAT_W)) bus();

  ex_branch_predictor #(.IDX_W(IDX_W), .STAT_W(STAT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] if_pc;
    bit          pred_en;
    bit          valid;
    bit          is_br;
    logic [31:0] ex_pc;
    bit          taken;
    bit          ptaken;
    bit          tclr;
    bit          sclr;
    bit          exp_pred;
    int          exp_b;
    int          exp_m;
  } vec_t;

  vec_t vecs[$];

  // Reference model: counter strength 0..3, prediction is strength >= 2.
  int mtbl [NENT];
  int mb, mm;

  function automatic int train(input int c, input bit t);
    if (t) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  function automatic vec_t mk(input logic [31:0] if_pc, input bit pe, input bit v,
                              input bit br, input logic [31:0] ex_pc, input bit t,
                              input bit pt, input bit tc, input bit sc, input bit ep,
                              input int eb, input int em);
    vec_t r;
    r.if_pc = if_pc; r.pred_en = pe; r.valid = v; r.is_br = br; r.ex_pc = ex_pc;
    r.taken = t; r.ptaken = pt; r.tclr = tc; r.sclr = sc; r.exp_pred = ep;
    r.exp_b = eb; r.exp_m = em;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.if_pc         = v.if_pc;
    bus.pred_en       = v.pred_en;
    bus.ex_valid      = v.valid;
    bus.ex_is_branch  = v.is_br;
    bus.ex_pc         = v.ex_pc;
    bus.ex_taken      = v.taken;
    bus.ex_pred_taken = v.ptaken;
    bus.tbl_clr       = v.tclr;
    bus.stat_clr      = v.sclr;
  endtask

  task automatic idle();
    apply(mk(32'h10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #2;
    check("reset_pred", {31'd0, bus.pred_taken}, 32'd0);
    check("reset_branch_cnt", 32'(bus.branch_cnt), 32'd0);
    check("reset_mispred_cnt", 32'(bus.mispred_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NENT; i++) mtbl[i] = 1;
    mb = 0;
    mm = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();

    //          if_pc  pe v br ex_pc t pt tc sc exp eb em
    vecs.push_back(mk(32'h10, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(32'h10, 1, 1, 1, 32'h5, 1, 0, 0, 0, 0,  1, 1));
    vecs.push_back(mk(32'h10, 1, 1, 1, 32'h5, 1, 0, 0, 0, 0,  2, 2));
    vecs.push_back(mk(32'h45, 1, 0, 0, 32'h0, 0, 0, 0, 0, 1,  2, 2));
    vecs.push_back(mk(32'h3,  1, 1, 1, 32'h3, 1, 1, 0, 0, 1,  3, 2));
    vecs.push_back(mk(32'h3,  1, 1, 1, 32'h3, 1, 1, 0, 0, 1,  4, 2));
    vecs.push_back(mk(32'h3,  1, 1, 1, 32'h3, 1, 1, 0, 0, 1,  5, 2));
    vecs.push_back(mk(32'h3,  1, 1, 1, 32'h3, 1, 1, 0, 0, 1,  6, 2));
    vecs.push_back(mk(32'h3,  1, 1, 1, 32'h3, 0, 1, 0, 0, 1,  7, 3));
    vecs.push_back(mk(32'h3,  1, 0, 0, 32'h0, 0, 0, 0, 0, 1,  7, 3));
    vecs.push_back(mk(32'h9,  1, 1, 1, 32'h9, 1, 0, 0, 0, 1,  8, 4));
    vecs.push_back(mk(32'hA,  0, 1, 1, 32'hA, 1, 0, 0, 0, 0,  9, 5));
    vecs.push_back(mk(32'hA,  1, 0, 0, 32'h0, 0, 0, 0, 0, 1,  9, 5));
    vecs.push_back(mk(32'h2,  1, 1, 1, 32'h2, 1, 1, 0, 0, 1, 10, 5));
    vecs.push_back(mk(32'h2,  1, 1, 1, 32'h2, 1, 1, 0, 0, 1, 11, 5));
    vecs.push_back(mk(32'h2,  1, 1, 1, 32'h2, 1, 1, 1, 0, 0, 12, 5));
    vecs.push_back(mk(32'h2,  1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 12, 5));
    vecs.push_back(mk(32'h5,  1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 12, 5));
    vecs.push_back(mk(32'h2,  1, 0, 1, 32'h2, 1, 0, 0, 0, 0, 12, 5));
    vecs.push_back(mk(32'h2,  1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 12, 5));
    vecs.push_back(mk(32'h7,  1, 1, 1, 32'h7, 1, 0, 0, 1, 1,  0, 0));
    vecs.push_back(mk(32'h7,  1, 0, 0, 32'h0, 0, 0, 0, 0, 1,  0, 0));

    do_reset();

    foreach (vecs[k]) begin
      @(negedge clk);
      apply(vecs[k]);
      #1;
      check($sformatf("vec%0d_pred", k), {31'd0, bus.pred_taken}, {31'd0, vecs[k].exp_pred});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_branch_cnt", k), 32'(bus.branch_cnt), 32'(vecs[k].exp_b));
      check($sformatf("vec%0d_mispred_cnt", k), 32'(bus.mispred_cnt), 32'(vecs[k].exp_m));
    end

    // Statistics saturation, then clear against a concurrent update.
    @(negedge clk);
    apply(mk(32'h10, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    @(negedge clk);
    apply(mk(32'h10, 1, 1, 1, 32'h11, 1, 0, 0, 0, 0, 0, 0));
    repeat (SMAX + 2) @(negedge clk);
    idle();
    #1;
    check("sat_branch_cnt", 32'(bus.branch_cnt), 32'(SMAX));
    check("sat_mispred_cnt", 32'(bus.mispred_cnt), 32'(SMAX));
    @(negedge clk);
    apply(mk(32'h10, 1, 1, 1, 32'h11, 1, 0, 0, 1, 0, 0, 0));
    @(posedge clk);
    #1;
    check("clr_branch_cnt", 32'(bus.branch_cnt), 32'd0);
    check("clr_mispred_cnt", 32'(bus.mispred_cnt), 32'd0);

    // Reset asserted while an update is pending discards the update.
    @(negedge clk);
    apply(mk(32'hC, 1, 1, 1, 32'hC, 1, 0, 0, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    apply(mk(32'hC, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("midrst_pred", {31'd0, bus.pred_taken}, 32'd0);
    check("midrst_branch_cnt", 32'(bus.branch_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_pred", {31'd0, bus.pred_taken}, 32'd0);

    // Randomized run against the model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      vec_t v;
      int ridx, widx, val;
      bit upd, ep;
      v.ex_pc   = $urandom;
      v.if_pc   = ($urandom_range(0, 2) == 0) ? {$urandom, v.ex_pc[IDX_W-1:0]} : $urandom;
      v.if_pc   = {v.if_pc[31:IDX_W], v.if_pc[IDX_W-1:0]};
      v.pred_en = ($urandom_range(0, 3) != 0);
      v.valid   = ($urandom_range(0, 3) != 0);
      v.is_br   = ($urandom_range(0, 2) != 0);
      v.taken   = ($urandom_range(0, 2) != 0);
      v.ptaken  = $urandom_range(0, 1);
      v.tclr    = ($urandom_range(0, 63) == 0);
      v.sclr    = ($urandom_range(0, 63) == 0);
      ridx = int'(v.if_pc % NENT);
      widx = int'(v.ex_pc % NENT);
      upd  = v.valid && v.is_br;
      val  = (upd && ridx == widx) ? train(mtbl[widx], v.taken) : mtbl[ridx];
      ep   = v.pred_en && !v.tclr && (val >= 2);

      @(negedge clk);
      apply(v);
      #1;
      check($sformatf("rnd%0d_pred", n), {31'd0, bus.pred_taken}, {31'd0, ep});

      if (v.tclr) for (int i = 0; i < NENT; i++) mtbl[i] = 1;
      else if (upd) mtbl[widx] = train(mtbl[widx], v.taken);
      if (v.sclr) begin
        mb = 0;
        mm = 0;
      end else if (upd) begin
        if (mb < SMAX) mb++;
        if (v.taken != v.ptaken && mm < SMAX) mm++;
      end

      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_branch_cnt", n), 32'(bus.branch_cnt), 32'(mb));
      check($sformatf("rnd%0d_mispred_cnt", n), 32'(bus.mispred_cnt), 32'(mm));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
